// File: rtl/cosine_sequencer.sv
// Control FSM ahead of the cosine datapath: drives its state code, collects the distance, and returns it over valid/ready.
// Optional watchdog abort on compute stalls is enabled with `define COSINE_SEQ_WATCHDOG_EN.
module cosine_sequencer #(
  parameter logic [15:0] ALERT_THRESHOLD = 16'h0400,
  parameter int unsigned WDOG_LIMIT      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_v,
  input  logic [15:0] req_x,
  output logic [3:0]  state,
  output logic [15:0] vSig,
  output logic [15:0] XSig,
  input  logic        done,
  input  logic        stop,
  input  logic [15:0] distance,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_alert,
  output logic        res_err,
  output logic        alert,
  input  logic        alert_ack
);

  typedef enum logic [2:0] {
    Idle,
    Start,
    Acc,
    Remult,
    Calc,
    Capture,
    Result,
    AlertSt
  } seqState_t;

  seqState_t   cur;
  seqState_t   nxt;
  logic [3:0]  stateNxt;
  logic        accept;
  logic        belowThreshold;
  logic        wdogAbort;

`ifdef COSINE_SEQ_WATCHDOG_EN
  localparam logic [7:0] WDOG_LAST = 8'(WDOG_LIMIT - 1);

  logic [7:0] wdogCnt;
  logic       isCompute;

  assign isCompute = (cur == Start) || (cur == Acc) || (cur == Remult) || (cur == Calc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdogCnt <= '0;
    end else if (accept) begin
      wdogCnt <= '0;
    end else if (isCompute) begin
      wdogCnt <= wdogCnt + 8'd1;
    end
  end
`else
  logic unusedWdogLimit;
  assign unusedWdogLimit = (WDOG_LIMIT == 0);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= Idle;
    end else begin
      cur <= nxt;
    end
  end

  // Next-state logic
  always_comb begin
    nxt       = cur;
    wdogAbort = 1'b0;
    case (cur)
      Idle:    if (req_valid) nxt = Start;
      Start:   nxt = Acc;
      Acc:     nxt = Remult;
      Remult:  nxt = stop ? Calc : Acc;
      Calc:    nxt = Capture;
      Capture: nxt = Result;
      Result:  if (res_valid && res_ready) nxt = res_alert ? AlertSt : Idle;
      AlertSt: if (alert_ack) nxt = Idle;
      default: nxt = Idle;
    endcase
`ifdef COSINE_SEQ_WATCHDOG_EN
    // Counter value equals cycles already spent computing; the last allowed cycle diverts to Result.
    if (isCompute && (wdogCnt >= WDOG_LAST)) begin
      nxt       = Result;
      wdogAbort = 1'b1;
    end
`endif
  end

  // Output decode
  always_comb begin
    req_ready      = (cur == Idle);
    accept         = req_valid && (cur == Idle);
    belowThreshold = ($signed(distance) < $signed(ALERT_THRESHOLD));
    stateNxt       = 4'd0;
    case (nxt)
      AlertSt: stateNxt = 4'd1;
      Start:   stateNxt = 4'd2;
      Acc:     stateNxt = 4'd3;
      Calc:    stateNxt = 4'd4;
      Remult:  stateNxt = 4'd5;
      default: stateNxt = 4'd0;
    endcase
  end

  // State code is registered from the next state so it lines up with the internal FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= '0;
      vSig      <= '0;
      XSig      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_alert <= 1'b0;
      res_err   <= 1'b0;
      alert     <= 1'b0;
    end else begin
      state <= stateNxt;
      alert <= (nxt == AlertSt);
      if (accept) begin
        vSig <= req_v;
        XSig <= req_x;
      end
      if (cur == Capture) begin
        res_valid <= 1'b1;
        res_data  <= distance;
        res_alert <= belowThreshold;
        res_err   <= ~done;
      end
`ifdef COSINE_SEQ_WATCHDOG_EN
      else if (wdogAbort) begin
        res_valid <= 1'b1;
        res_data  <= '0;
        res_alert <= 1'b0;
        res_err   <= 1'b1;
      end
`endif
      else if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cosine_sequencer.sv
// Directed bench for cosine_sequencer with a small behavioural datapath (cos(0)=1, so distance follows vSig).
module tb_cosine_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_v;
  logic [15:0] req_x;
  logic [3:0]  state;
  logic [15:0] vSig;
  logic [15:0] XSig;
  logic        done;
  logic        stop;
  logic [15:0] distance;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_alert;
  logic        res_err;
  logic        alert;
  logic        alert_ack;

  int errors = 0;
  int checks = 0;

  logic [3:0]  termCnt  = '0;
  logic        dpStop   = 1'b0;
  logic        dpDone   = 1'b0;
  logic [15:0] dpDist   = '0;
  logic        forceStop    = 1'b0;
  logic        forceNoStop  = 1'b0;
  logic        suppressDone = 1'b0;

  always #5 clk = ~clk;

  cosine_sequencer #(
    .ALERT_THRESHOLD(16'h0400),
    .WDOG_LIMIT(32)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_v(req_v), .req_x(req_x),
    .state(state), .vSig(vSig), .XSig(XSig),
    .done(done), .stop(stop), .distance(distance),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_alert(res_alert), .res_err(res_err),
    .alert(alert), .alert_ack(alert_ack)
  );

  // Datapath model: term counter, stop after the 8th accumulate, distance at CalcDistance.
  always @(posedge clk) begin
    case (state)
      4'd2: begin termCnt <= '0; dpStop <= 1'b0; dpDone <= 1'b0; end
      4'd3: begin termCnt <= termCnt + 4'd1; dpStop <= !forceNoStop && (termCnt == 4'd7); end
      4'd4: begin dpDist <= vSig; dpDone <= !suppressDone; end
      default: ;
    endcase
  end

  assign stop     = forceStop | dpStop;
  assign done     = dpDone;
  assign distance = dpDist;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected state code k edges after acceptance for a run of n ACC/REMULT pairs.
  function automatic logic [3:0] seqCode(input int k, input int n);
    if (k == 0) return 4'd2;
    if (k <= 2 * n) return (k % 2 == 1) ? 4'd3 : 4'd5;
    if (k == 2 * n + 1) return 4'd4;
    return 4'd0;
  endfunction

  task automatic runToResult(input logic [15:0] v, input logic [15:0] x, input int expLat,
                             input int pairs, input bit checkSeq, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    checkVal({tag, "_idle_state"}, 32'(state), 32'd0);
    checkVal({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_v     = v;
    req_x     = x;
    req_valid = 1'b1;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (checkSeq) checkVal($sformatf("%s_state%0d", tag, k), 32'(state), 32'(seqCode(k, pairs)));
      if (res_valid) begin
        lat = k;
        break;
      end
    end
    checkVal({tag, "_latency"}, 32'(lat), 32'(expLat));
  endtask

  task automatic finishRun(input bit expAlert, input string tag);
    @(negedge clk);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checkVal({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
    if (expAlert) begin
      checkVal({tag, "_alert_state"}, 32'(state), 32'd1);
      checkVal({tag, "_alert_hi"}, 32'(alert), 32'd1);
      repeat (3) @(negedge clk);
      checkVal({tag, "_alert_held"}, 32'(alert), 32'd1);
      checkVal({tag, "_req_ready_alert"}, 32'(req_ready), 32'd0);
      alert_ack = 1'b1;
      @(negedge clk);
      alert_ack = 1'b0;
    end
    checkVal({tag, "_back_idle"}, 32'(state), 32'd0);
    checkVal({tag, "_alert_lo"}, 32'(alert), 32'd0);
    checkVal({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
  endtask

  task automatic resultCheck(input logic [15:0] expData, input bit expAlert, input bit expErr,
                             input string tag);
    checkVal({tag, "_data"}, 32'(res_data), 32'(expData));
    checkVal({tag, "_res_alert"}, 32'(res_alert), 32'(expAlert));
    checkVal({tag, "_res_err"}, 32'(res_err), 32'(expErr));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_v     = '0;
    req_x     = '0;
    res_ready = 1'b0;
    alert_ack = 1'b0;
    #12;
    checkVal("rst_state", 32'(state), 32'd0);
    checkVal("rst_vSig", 32'(vSig), 32'd0);
    checkVal("rst_XSig", 32'(XSig), 32'd0);
    checkVal("rst_res_valid", 32'(res_valid), 32'd0);
    checkVal("rst_res_data", 32'(res_data), 32'd0);
    checkVal("rst_res_alert", 32'(res_alert), 32'd0);
    checkVal("rst_res_err", 32'(res_err), 32'd0);
    checkVal("rst_alert", 32'(alert), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unit V, zero angle: full sequence and 19-edge latency
    runToResult(16'h0800, 16'h0000, 19, 8, 1'b1, "t1");
    resultCheck(16'h0800, 1'b0, 1'b0, "t1");
    checkVal("t1_vSig", 32'(vSig), 32'h0800);
    checkVal("t1_XSig", 32'(XSig), 32'h0000);
    checkVal("t1_req_ready_busy", 32'(req_ready), 32'd0);
    finishRun(1'b0, "t1");

    // res_ready while nothing is pending must not disturb IDLE
    res_ready = 1'b1;
    repeat (2) @(negedge clk);
    checkVal("idle_rr_state", 32'(state), 32'd0);
    checkVal("idle_rr_valid", 32'(res_valid), 32'd0);
    res_ready = 1'b0;

    // Small V raises alert; backpressure holds result, later requests and acks ignored
    runToResult(16'h0200, 16'h0000, 19, 8, 1'b0, "t2");
    resultCheck(16'h0200, 1'b1, 1'b0, "t2");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      req_valid = 1'b1;
      req_v     = 16'h1234;
      req_x     = 16'h0567;
      alert_ack = 1'b1;
    end
    @(negedge clk);
    req_valid = 1'b0;
    alert_ack = 1'b0;
    checkVal("t3_valid_held", 32'(res_valid), 32'd1);
    checkVal("t3_data_held", 32'(res_data), 32'h0200);
    checkVal("t3_req_ready", 32'(req_ready), 32'd0);
    checkVal("t3_vSig_held", 32'(vSig), 32'h0200);
    checkVal("t3_XSig_held", 32'(XSig), 32'h0000);
    checkVal("t3_state", 32'(state), 32'd0);
    checkVal("t3_alert_lo", 32'(alert), 32'd0);
    finishRun(1'b1, "t2");

    // Threshold boundary and signed comparison
    runToResult(16'h0400, 16'h0000, 19, 8, 1'b0, "thr_eq");
    resultCheck(16'h0400, 1'b0, 1'b0, "thr_eq");
    finishRun(1'b0, "thr_eq");
    runToResult(16'h03FF, 16'h0000, 19, 8, 1'b0, "thr_lo");
    resultCheck(16'h03FF, 1'b1, 1'b0, "thr_lo");
    finishRun(1'b1, "thr_lo");
    runToResult(16'hF800, 16'h0000, 19, 8, 1'b0, "thr_neg");
    resultCheck(16'hF800, 1'b1, 1'b0, "thr_neg");
    finishRun(1'b1, "thr_neg");

    // stop held high everywhere: only REMULT may act on it
    forceStop = 1'b1;
    runToResult(16'h0800, 16'h0000, 5, 1, 1'b1, "early");
    forceStop = 1'b0;
    resultCheck(16'h0800, 1'b0, 1'b0, "early");
    finishRun(1'b0, "early");

    // Asynchronous reset in REMULT, then a clean run
    @(negedge clk);
    req_v     = 16'h0800;
    req_x     = 16'h0000;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    begin
      int waited;
      waited = 0;
      while (state !== 4'd5 && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      checkVal("t4_reach_remult", 32'(state), 32'd5);
    end
    #2 rst_n = 1'b0;
    #1;
    checkVal("t4_rst_state", 32'(state), 32'd0);
    checkVal("t4_rst_vSig", 32'(vSig), 32'd0);
    checkVal("t4_rst_valid", 32'(res_valid), 32'd0);
    checkVal("t4_rst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    runToResult(16'h0800, 16'h0000, 19, 8, 1'b1, "t4");
    resultCheck(16'h0800, 1'b0, 1'b0, "t4");
    finishRun(1'b0, "t4");

    // Datapath done low at capture flags an error but still returns the distance
    suppressDone = 1'b1;
    runToResult(16'h0100, 16'h0000, 19, 8, 1'b0, "nodone");
    suppressDone = 1'b0;
    resultCheck(16'h0100, 1'b1, 1'b1, "nodone");
    finishRun(1'b1, "nodone");
    runToResult(16'h0C00, 16'h0000, 19, 8, 1'b0, "clean");
    resultCheck(16'h0C00, 1'b0, 1'b0, "clean");
    finishRun(1'b0, "clean");

`ifdef COSINE_SEQ_WATCHDOG_EN
    forceNoStop = 1'b1;
    runToResult(16'h0800, 16'h0000, 32, 8, 1'b0, "wdog");
    forceNoStop = 1'b0;
    resultCheck(16'h0000, 1'b0, 1'b1, "wdog");
    finishRun(1'b0, "wdog");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
